// File: rtl/prbs7_data_generator_if.sv
//------------------------------------------------------------------------------
// Module   : prbs7_data_generator_if
// Brief    : Control/data bundle between test-control registers, the PRBS7
//            word generator and the serializer TX word input.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface prbs7_data_generator_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 enable;
  logic                 load_seed;
  logic [6:0]           seed_in;
  logic                 inj_req;
  logic [4:0]           inj_bit;
  logic [31:0]          DataOut;
  logic                 data_valid;
  logic                 inj_busy;
  logic [CNT_WIDTH-1:0] word_count;
  logic [CNT_WIDTH-1:0] inj_count;

  // Control side: drives requests, observes the generated stream and status
  modport master (
    output enable, load_seed, seed_in, inj_req, inj_bit,
    input  DataOut, data_valid, inj_busy, word_count, inj_count
  );

  // Generator side
  modport slave (
    input  enable, load_seed, seed_in, inj_req, inj_bit,
    output DataOut, data_valid, inj_busy, word_count, inj_count
  );
endinterface

`default_nettype wire

// File: rtl/prbs7_data_generator.sv
//------------------------------------------------------------------------------
// Module   : prbs7_data_generator
// Brief    : 32-bit-per-clock PRBS7 (x^7 + x^6 + 1) word source with seed
//            load, clock-enable hold and one-shot single-bit error injection.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module prbs7_data_generator #(
  parameter logic [6:0] INIT_SEED = 7'h7F,
  parameter int         CNT_WIDTH = 32
) (
  input  wire logic            clock,
  input  wire logic            reset_n,
  prbs7_data_generator_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_one  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [31:0]          c_word_one = 32'd1;

  // r_state[6] is the oldest of the last 7 emitted bits, r_state[0] the newest
  logic [6:0]           r_state;
  logic [31:0]          r_data;
  logic                 r_valid;
  logic                 r_inj_busy;
  logic [4:0]           r_inj_idx;
  logic [CNT_WIDTH-1:0] r_word_count;
  logic [CNT_WIDTH-1:0] r_inj_count;

  // w_ext[38:32] is the current state, w_ext[31:0] the next word, so the
  // recurrence bit p = bit(p+7) ^ bit(p+6) runs straight across the boundary
  logic [38:0]          w_ext;
  logic                 w_emit;
  logic                 w_inj_apply;
  logic [4:0]           w_inj_idx;
  logic [31:0]          w_inj_mask;
  logic [6:0]           w_seed;

  // 32-step unrolling of the serial LFSR recurrence
  always_comb begin
    w_ext        = '0;
    w_ext[38:32] = r_state;
    for (int i = 31; i >= 0; i--) begin
      w_ext[i] = w_ext[i+7] ^ w_ext[i+6];
    end
  end

  // Seed load wins over enable; an armed or same-edge injection request is
  // applied on the first edge that actually emits a word
  always_comb begin
    w_emit      = bus.enable && !bus.load_seed;
    w_inj_apply = w_emit && (r_inj_busy || bus.inj_req);
    w_inj_idx   = r_inj_busy ? r_inj_idx : bus.inj_bit;
    w_inj_mask  = w_inj_apply ? (c_word_one << w_inj_idx) : 32'd0;
    w_seed      = (bus.seed_in == 7'd0) ? INIT_SEED : bus.seed_in;
  end

  // Generator state, output word, injection arming and counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= INIT_SEED;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_inj_busy   <= 1'b0;
      r_inj_idx    <= '0;
      r_word_count <= '0;
      r_inj_count  <= '0;
    end else begin
      if (bus.load_seed) begin
        r_state <= w_seed;
        r_valid <= 1'b0;
      end else if (bus.enable) begin
        // The flip touches the output only; the state keeps the clean bits
        r_data       <= w_ext[31:0] ^ w_inj_mask;
        r_state      <= w_ext[6:0];
        r_valid      <= 1'b1;
        r_word_count <= r_word_count + c_cnt_one;
      end else begin
        r_valid <= 1'b0;
      end

      if (w_inj_apply) begin
        r_inj_busy  <= 1'b0;
        r_inj_count <= r_inj_count + c_cnt_one;
      end else if (bus.inj_req && !r_inj_busy) begin
        r_inj_busy <= 1'b1;
        r_inj_idx  <= bus.inj_bit;
      end
    end
  end

  assign bus.DataOut    = r_data;
  assign bus.data_valid = r_valid;
  assign bus.inj_busy   = r_inj_busy;
  assign bus.word_count = r_word_count;
  assign bus.inj_count  = r_inj_count;

endmodule

`default_nettype wire

// File: tb/tb_prbs7_data_generator.sv
//------------------------------------------------------------------------------
// Module   : tb_prbs7_data_generator
// Brief    : Self-checking bench for prbs7_data_generator with a serial
//            reference model and an expected-word scoreboard queue.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_prbs7_data_generator;

  localparam int         CW   = 32;
  localparam logic [6:0] SEED = 7'h7F;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  prbs7_data_generator_if #(.CNT_WIDTH(CW)) bus ();

  prbs7_data_generator #(
    .INIT_SEED (SEED),
    .CNT_WIDTH (CW)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0]   exp_q[$];

  // Reference model state
  logic [6:0]    m_st;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_busy;
  logic [4:0]    m_idx;
  logic [CW-1:0] m_wc;
  logic [CW-1:0] m_ic;
  logic [31:0]   prev_word;
  logic          prev_ok;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Serial PRBS7: s[k] = s[k-7] ^ s[k-6], earliest bit lands in word bit 31
  task automatic model_next(output logic [31:0] w);
    logic b;
    w = '0;
    for (int k = 0; k < 32; k++) begin
      b    = m_st[6] ^ m_st[5];
      m_st = {m_st[5:0], b};
      w    = {w[30:0], b};
    end
  endtask

  function automatic int rel_errs(input logic [63:0] c);
    int n = 0;
    for (int p = 0; p <= 56; p++) begin
      if (c[p] !== (c[p+7] ^ c[p+6])) n++;
    end
    return n;
  endfunction

  task automatic model_reset();
    m_st    = SEED;
    m_data  = '0;
    m_valid = 1'b0;
    m_busy  = 1'b0;
    m_idx   = '0;
    m_wc    = '0;
    m_ic    = '0;
    prev_ok = 1'b0;
    exp_q.delete();
  endtask

  // Called at posedge+1: assert reset, check async clear, release before next edge
  task automatic do_reset();
    reset_n       = 1'b0;
    bus.enable    = 1'b0;
    bus.load_seed = 1'b0;
    bus.seed_in   = '0;
    bus.inj_req   = 1'b0;
    bus.inj_bit   = '0;
    #1;
    model_reset();
    chk("reset_data",  {32'd0, bus.DataOut},     64'd0);
    chk("reset_valid", {63'd0, bus.data_valid},  64'd0);
    chk("reset_busy",  {63'd0, bus.inj_busy},    64'd0);
    chk("reset_wc",    {32'd0, bus.word_count},  64'd0);
    chk("reset_ic",    {32'd0, bus.inj_count},   64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge
  task automatic cycle(input logic en, input logic ld, input logic [6:0] sd,
                       input logic ir, input logic [4:0] ib);
    logic [31:0] w;
    logic [31:0] got;
    logic [4:0]  idx;
    logic        emit;
    logic        inj_this;
    bus.enable    = en;
    bus.load_seed = ld;
    bus.seed_in   = sd;
    bus.inj_req   = ir;
    bus.inj_bit   = ib;

    emit     = en && !ld;
    inj_this = 1'b0;
    if (ld) begin
      m_st    = (sd == 7'd0) ? SEED : sd;
      m_valid = 1'b0;
      prev_ok = 1'b0;
    end else if (en) begin
      model_next(w);
      if (m_busy || ir) begin
        idx      = m_busy ? m_idx : ib;
        w[idx]   = ~w[idx];
        m_busy   = 1'b0;
        m_ic     = m_ic + 1;
        inj_this = 1'b1;
      end
      exp_q.push_back(w);
      m_data  = w;
      m_valid = 1'b1;
      m_wc    = m_wc + 1;
    end else begin
      m_valid = 1'b0;
    end
    if (!emit && ir && !m_busy) begin
      m_busy = 1'b1;
      m_idx  = ib;
    end

    @(posedge clock);
    #1;
    chk("data_valid", {63'd0, bus.data_valid}, {63'd0, m_valid});
    chk("inj_busy",   {63'd0, bus.inj_busy},   {63'd0, m_busy});
    chk("word_count", {32'd0, bus.word_count}, {32'd0, m_wc});
    chk("inj_count",  {32'd0, bus.inj_count},  {32'd0, m_ic});
    chk("data_held",  {32'd0, bus.DataOut},    {32'd0, m_data});
    if (bus.data_valid === 1'b1) begin
      got = bus.DataOut;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 64'd1, 64'd0);
      end else begin
        w = exp_q.pop_front();
        chk("sb_word", {32'd0, got}, {32'd0, w});
      end
      if (prev_ok && !inj_this) begin
        chk("pair_relation", 64'(rel_errs({prev_word, got})), 64'd0);
      end
      prev_word = got;
      prev_ok   = !inj_this;
    end
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.load_seed = 1'b0;
    bus.seed_in   = '0;
    bus.inj_req   = 1'b0;
    bus.inj_bit   = '0;
    model_reset();
    @(posedge clock);
    #1;
    do_reset();

    // Continuous run from reset: first word, period wrap, long clean stream
    cycle(1'b1, 1'b0, 7'h00, 1'b0, 5'd0);
    chk("first_word_const", {32'd0, bus.DataOut},    {32'd0, 32'h020C_28F2});
    chk("first_wc_const",   {32'd0, bus.word_count}, 64'd1);
    for (int n = 2; n <= 128; n++) cycle(1'b1, 1'b0, 7'h00, 1'b0, 5'd0);
    chk("word128_const", {32'd0, bus.DataOut}, {32'd0, 32'h020C_28F2});
    for (int n = 129; n <= 1000; n++) cycle(1'b1, 1'b0, 7'h00, 1'b0, 5'd0);

    // Enable hold: 1,0,0,1
    cycle(1'b1, 1'b0, 7'h00, 1'b0, 5'd0);
    cycle(1'b0, 1'b0, 7'h00, 1'b0, 5'd0);
    cycle(1'b0, 1'b0, 7'h00, 1'b0, 5'd0);
    cycle(1'b1, 1'b0, 7'h00, 1'b0, 5'd0);

    // Nonzero seed load mid-stream, with enable high on the load edge
    cycle(1'b1, 1'b1, 7'h2A, 1'b0, 5'd0);
    for (int n = 0; n < 6; n++) cycle(1'b1, 1'b0, 7'h00, 1'b0, 5'd0);

    // Zero seed substitutes the reset seed
    @(posedge clock);
    #1;
    do_reset();
    cycle(1'b1, 1'b1, 7'h00, 1'b0, 5'd0);
    chk("zero_seed_hold", {32'd0, bus.DataOut}, 64'd0);
    cycle(1'b1, 1'b0, 7'h00, 1'b0, 5'd0);
    chk("zero_seed_word", {32'd0, bus.DataOut}, {32'd0, 32'h020C_28F2});

    // Injection on the same edge as the request, bit 31
    @(posedge clock);
    #1;
    do_reset();
    cycle(1'b1, 1'b0, 7'h00, 1'b1, 5'd31);
    chk("inj31_word_const", {32'd0, bus.DataOut},   {32'd0, 32'h820C_28F2});
    chk("inj31_ic_const",   {32'd0, bus.inj_count}, 64'd1);
    cycle(1'b1, 1'b0, 7'h00, 1'b0, 5'd0);
    cycle(1'b1, 1'b0, 7'h00, 1'b0, 5'd0);

    // Armed while held; second request ignored; survives a seed load
    cycle(1'b0, 1'b0, 7'h00, 1'b1, 5'd0);
    chk("armed_busy_const", {63'd0, bus.inj_busy}, 64'd1);
    cycle(1'b0, 1'b0, 7'h00, 1'b1, 5'd5);
    cycle(1'b0, 1'b1, 7'h11, 1'b0, 5'd0);
    cycle(1'b1, 1'b0, 7'h00, 1'b0, 5'd0);
    chk("armed_ic_const", {32'd0, bus.inj_count}, 64'd2);
    cycle(1'b1, 1'b0, 7'h00, 1'b0, 5'd0);

    // Request on a load edge arms but does not apply
    cycle(1'b1, 1'b1, 7'h40, 1'b1, 5'd17);
    cycle(1'b1, 1'b0, 7'h00, 1'b0, 5'd0);
    cycle(1'b1, 1'b0, 7'h00, 1'b0, 5'd0);

    // Reset while armed clears inj_busy asynchronously
    cycle(1'b0, 1'b0, 7'h00, 1'b1, 5'd3);
    chk("pre_reset_busy", {63'd0, bus.inj_busy}, 64'd1);
    do_reset();
    cycle(1'b1, 1'b0, 7'h00, 1'b0, 5'd0);
    chk("post_reset_word", {32'd0, bus.DataOut}, {32'd0, 32'h020C_28F2});

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
